// File: rtl/neural_fifo_pkg.sv
// Shared types and defaults for the neural-data FIFO write scheduler.
package neural_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } nfws_state_t;

  localparam int NFWS_FRAME_WORDS = 1400;
  localparam int NFWS_FIFO_DEPTH  = 4096;
  localparam int NFWS_MARGIN      = 16;
  localparam int NFWS_EVT_DEPTH   = 16;
  localparam int NFWS_DATA_W      = 16;
  localparam int NFWS_WRCNT_W     = 13;
  localparam int NFWS_DROP_W      = 16;

  // Word counter must hold the value FRAME_WORDS itself.
  function automatic int nfws_cnt_w(input int frame_words);
    return $clog2(frame_words + 1);
  endfunction

endpackage

// File: rtl/nfws_event_queue.sv
// First-word-fall-through queue holding auxiliary event words until an inter-frame gap.
module nfws_event_queue #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full queue is taken when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/neural_fifo_write_scheduler.sv
// Sole writer of the neural-data FIFO: admits or drops whole SPI frames by free space,
// slots queued event words into inter-frame gaps, and keeps sticky host status.
module neural_fifo_write_scheduler
  import neural_fifo_pkg::*;
#(
  parameter int FRAME_WORDS = NFWS_FRAME_WORDS,
  parameter int FIFO_DEPTH  = NFWS_FIFO_DEPTH,
  parameter int MARGIN      = NFWS_MARGIN,
  parameter int EVT_DEPTH   = NFWS_EVT_DEPTH,
  parameter bit STOP_ON_OVF = 1'b1
) (
  input  logic                    dataclk,
  input  logic                    fifo_reset,
  input  logic [NFWS_DATA_W-1:0]  spi_word,
  input  logic                    spi_wen,
  input  logic                    spi_frame_start,
  input  logic                    evt_valid,
  input  logic [NFWS_DATA_W-1:0]  evt_data,
  output logic                    evt_ready,
  input  logic [NFWS_WRCNT_W-1:0] fifo_wr_count,
  input  logic                    fifo_full,
  output logic [NFWS_DATA_W-1:0]  fifo_din,
  output logic                    fifo_wen,
  output logic                    overflow,
  output logic                    frame_err,
  output logic [NFWS_DROP_W-1:0]  dropped_frames,
  output logic [1:0]              o_dbg_state
);
  localparam int          CNT_W      = nfws_cnt_w(FRAME_WORDS);
  localparam int          QCNT_W     = $clog2(EVT_DEPTH) + 1;
  localparam logic [31:0] ADMIT_NEED = 32'(FRAME_WORDS + MARGIN);
  localparam logic [31:0] FREE_MAX   = 32'(FIFO_DEPTH - 1);

  nfws_state_t             r_state;
  logic [CNT_W-1:0]        r_word_cnt;
  logic [NFWS_DATA_W-1:0]  r_fifo_din;
  logic                    r_fifo_wen;
  logic                    r_overflow;
  logic                    r_frame_err;
  logic [NFWS_DROP_W-1:0]  r_dropped;

  logic [31:0]             w_fill;
  logic                    w_fits;
  logic                    w_evt_fits;
  logic                    w_new_frame;
  logic                    w_stray;
  logic                    w_cont;
  logic [CNT_W-1:0]        w_next_cnt;
  logic                    w_last;
  logic                    w_spi_write;
  logic                    w_block;
  logic                    w_count_drop;
  logic                    w_evt_push;
  logic                    w_evt_pop;
  logic [NFWS_DATA_W-1:0]  w_q_data;
  logic                    w_q_empty;
  logic [QCNT_W-1:0]       w_q_count;

  // Event handshake: a word transfers on any dataclk edge where evt_valid and evt_ready
  // are both high; evt_ready depends only on queue occupancy, never on evt_valid.
  assign evt_ready  = (w_q_count != QCNT_W'(EVT_DEPTH));
  assign w_evt_push = evt_valid & evt_ready;

  // free >= need  <=>  wr_count + need <= FIFO_DEPTH-1, kept in 32 bits to avoid underflow.
  assign w_fill     = 32'(fifo_wr_count) + ADMIT_NEED;
  assign w_fits     = (w_fill <= FREE_MAX);
  assign w_evt_fits = (w_fill <  FREE_MAX);

  always_comb begin
    w_new_frame  = spi_wen & spi_frame_start;
    w_stray      = spi_wen & ~spi_frame_start & (r_state == ST_IDLE);
    w_cont       = spi_wen & ~spi_frame_start & (r_state != ST_IDLE);
    w_next_cnt   = w_new_frame ? CNT_W'(1) : (r_word_cnt + CNT_W'(1));
    w_last       = (w_next_cnt == CNT_W'(FRAME_WORDS));
    w_spi_write  = (w_new_frame & w_fits) | (w_cont & (r_state == ST_PASS));
    w_block      = STOP_ON_OVF & r_overflow;
    w_count_drop = w_new_frame & (~w_fits | w_block);
    w_evt_pop    = (r_state == ST_IDLE) & ~spi_wen & ~w_q_empty & w_evt_fits;
  end

  nfws_event_queue #(
    .DEPTH (EVT_DEPTH),
    .W     (NFWS_DATA_W)
  ) u_evq (
    .i_clk   (dataclk),
    .i_rst   (fifo_reset),
    .i_push  (w_evt_push),
    .i_pop   (w_evt_pop),
    .i_data  (evt_data),
    .o_data  (w_q_data),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  always_ff @(posedge dataclk or posedge fifo_reset) begin
    if (fifo_reset) begin
      r_state     <= ST_IDLE;
      r_word_cnt  <= '0;
      r_fifo_din  <= '0;
      r_fifo_wen  <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
      r_dropped   <= '0;
    end else begin
      r_fifo_wen <= ~w_block & ((w_spi_write & ~fifo_full) | w_evt_pop);
      if (w_spi_write)    r_fifo_din <= spi_word;
      else if (w_evt_pop) r_fifo_din <= w_q_data;

      // A start word always opens a fresh frame, abandoning any partial one.
      if (w_new_frame | w_cont) begin
        r_word_cnt <= w_last ? '0 : w_next_cnt;
        if (w_last)           r_state <= ST_IDLE;
        else if (w_new_frame) r_state <= w_fits ? ST_PASS : ST_DROP;
      end

      if (w_stray | (w_new_frame & (r_state != ST_IDLE))) r_frame_err <= 1'b1;
      if ((w_new_frame & ~w_fits) | (w_spi_write & fifo_full)) r_overflow <= 1'b1;
      if (w_count_drop && (r_dropped != '1)) r_dropped <= r_dropped + NFWS_DROP_W'(1);
    end
  end

  assign fifo_din       = r_fifo_din;
  assign fifo_wen       = r_fifo_wen;
  assign overflow       = r_overflow;
  assign frame_err      = r_frame_err;
  assign dropped_frames = r_dropped;
  assign o_dbg_state    = r_state;

endmodule
